mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
- Multi-cycle MIPS controller; next generation of the single-cycle decoder.
- Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives the shared-ALU, shared-memory datapath.
- Adds: a variable-latency memory handshake (mem_ready), optional bne/andi/ori support, and an illegal-opcode flag.
- Sits between the instruction register/ALU zero flag and the datapath muxes/enables.

Parameters:
- EN_BNE, 1, 1 = decode bne (op 000101); 0 = treat it as illegal.
- EN_LOGIC_IMM, 1, 1 = decode andi (001100) and ori (001101), which use a zero-extended immediate; 0 = illegal.
- ALUCTL_W, 3, ALUControl width; values use the low 3 bits and the upper bits are zero when wider.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = Data register, 0 = ALUOut
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- zext_imm  out  1  immediate is zero-extended (andi/ori)
- alu_control  out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load enable
- illegal_op  out  1  one-cycle pulse on an undecodable op/funct
- state_o  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11. Codes 12-15 are unused and go to FETCH next cycle with all strobes 0.
- Reset: rst_n low forces state FETCH immediately (asynchronous). While in reset: mem_write=0, reg_write=0, pc_en=0, ir_write=0, illegal_op=0. All outputs are registered-state decodes; there is no other internal storage.
- Unlisted outputs are 0 in every state; alu_control=010 unless stated.
- FETCH:
  - iord=0, alu_src_a=0, alu_src_b=01, pc_src=00.
  - ir_write=mem_ready, pc_en=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11 (branch target into ALUOut).
  - Next state: lw/sw -> MEMADR; R-type -> EXEC; addi/andi/ori -> IMMEX; beq/bne -> BRANCH; j -> JUMP.
  - Any other op, or R-type with funct not in {100000, 100010, 100100, 100101, 101010}: illegal_op=1 this cycle, next state FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; then FETCH.
- MEMWR: iord=1, mem_write=1, held high until mem_ready. Exits to FETCH on the mem_ready cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct. Then ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; then FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10. addi -> add, andi -> and, ori -> or. zext_imm=1 for andi/ori. Then IMMWB.
- IMMWB: reg_dst=0, reg_write=1; zext_imm and alu_control held from IMMEX. Then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_en = zero for beq, ~zero for bne.
  - Then FETCH.
- JUMP: pc_src=10, pc_en=1; then FETCH.
- op and funct are sampled every cycle; the IR must stay stable from DECODE to writeback.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Instruction cycle counts with zero wait states:
  - lw: 5
  - R-type / imm: 4
  - sw: 4
  - beq/bne: 3
  - j: 3
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction aborts it; no write strobe is issued after rst_n falls.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release with mem_ready=1 -> state_o=0 during reset. First cycle after release: pc_en=1, ir_write=1. Next cycle: state_o=1.
- lw, op=100011, mem_ready=1 -> states 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=1. 5 cycles total.
- sw with mem_ready low for 2 cycles in MEMWR -> mem_write=1 for exactly 3 cycles, then state 0. No reg_write at any point.
- R-type funct=101010 -> alu_control=111 in EXEC; reg_write=1, reg_dst=1 in ALUWB. funct=000000 -> illegal_op pulse in DECODE, return to FETCH, no reg_write.
- beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH. bne with zero=1 -> pc_en=0. With EN_BNE=0, op=000101 -> illegal_op=1.
- ori, op=001101 -> zext_imm=1 and alu_control=001 in IMMEX and IMMWB. Reset pulsed during IMMEX -> no reg_write, state 0.

Source files
------------

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB); outputs decode the state register and IR fields in the same cycle.
// Memory backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; write strobes are forced low while rst_n is low.
module mc_ctrl_unit #(
   parameter int EN_BNE       = 1,
   parameter int EN_LOGIC_IMM = 1,
   parameter int ALUCTL_W     = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                iord,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                zext_imm,
   output logic [ALUCTL_W-1:0] alu_control,
   output logic [1:0]          pc_src,
   output logic                pc_en,
   output logic                illegal_op,
   output logic [3:0]          state_o
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t state_q, state_d;

   logic is_lw, is_sw, is_r, is_addi, is_andi, is_ori, is_beq, is_bne, is_j;
   logic funct_ok;
   logic [2:0] funct_alu, imm_alu, alu3;
   logic mem_write_c, reg_write_c, pc_en_c, ir_write_c, illegal_c;

   assign is_lw   = (op == 6'b100011);
   assign is_sw   = (op == 6'b101011);
   assign is_r    = (op == 6'b000000);
   assign is_addi = (op == 6'b001000);
   assign is_andi = (EN_LOGIC_IMM != 0) && (op == 6'b001100);
   assign is_ori  = (EN_LOGIC_IMM != 0) && (op == 6'b001101);
   assign is_beq  = (op == 6'b000100);
   assign is_bne  = (EN_BNE != 0) && (op == 6'b000101);
   assign is_j    = (op == 6'b000010);

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Immediate ops keep the same ALU op and extension through IMMWB since IR is stable.
   assign imm_alu = is_andi ? ALU_AND : (is_ori ? ALU_OR : ALU_ADD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = S_FETCH;
      iord        = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write_c = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      zext_imm    = 1'b0;
      alu3        = ALU_ADD;
      pc_src      = 2'b00;
      pc_en_c     = 1'b0;
      illegal_c   = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b  = 2'b01;
            ir_write_c = mem_ready;
            pc_en_c    = mem_ready;
            state_d    = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            if (is_lw || is_sw)                      state_d = S_MEMADR;
            else if (is_r && funct_ok)               state_d = S_EXEC;
            else if (is_addi || is_andi || is_ori)   state_d = S_IMMEX;
            else if (is_beq || is_bne)               state_d = S_BRANCH;
            else if (is_j)                           state_d = S_JUMP;
            else begin
               illegal_c = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (is_lw)      state_d = S_MEMRD;
            else if (is_sw) state_d = S_MEMWR;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            mem_to_reg  = 1'b1;
            reg_write_c = 1'b1;
         end
         S_MEMWR: begin
            iord        = 1'b1;
            mem_write_c = 1'b1;
            state_d     = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu3      = funct_alu;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst     = 1'b1;
            reg_write_c = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu3      = ALU_SUB;
            pc_src    = 2'b01;
            pc_en_c   = is_bne ? ~zero : (is_beq & zero);
         end
         S_IMMEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            zext_imm  = is_andi | is_ori;
            alu3      = imm_alu;
            state_d   = S_IMMWB;
         end
         S_IMMWB: begin
            reg_write_c = 1'b1;
            zext_imm    = is_andi | is_ori;
            alu3        = imm_alu;
         end
         S_JUMP: begin
            pc_src  = 2'b10;
            pc_en_c = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Strobes are qualified by rst_n so nothing fires during the async reset window.
   assign mem_write   = mem_write_c & rst_n;
   assign reg_write   = reg_write_c & rst_n;
   assign pc_en       = pc_en_c & rst_n;
   assign ir_write    = ir_write_c & rst_n;
   assign illegal_op  = illegal_c & rst_n;
   assign alu_control = ALUCTL_W'(alu3);
   assign state_o     = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit; a second instance with bne disabled checks the illegal path.
module tb_mc_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op, funct;
   logic       zero, mem_ready;

   logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, zext_imm, pc_en, illegal_op;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic [3:0] state_o;

   logic       iord2, mem_write2, ir_write2, reg_dst2, mem_to_reg2, reg_write2;
   logic       alu_src_a2, zext_imm2, pc_en2, illegal_op2;
   logic [1:0] alu_src_b2, pc_src2;
   logic [2:0] alu_control2;
   logic [3:0] state_o2;

   int errors = 0;
   int checks = 0;
   int rw_cnt = 0;
   int mw_cnt = 0;
   int rw_base, mw_base;

   always #5 clk = ~clk;

   mc_ctrl_unit #(.EN_BNE(1), .EN_LOGIC_IMM(1), .ALUCTL_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .zext_imm(zext_imm), .alu_control(alu_control),
      .pc_src(pc_src), .pc_en(pc_en), .illegal_op(illegal_op), .state_o(state_o)
   );

   mc_ctrl_unit #(.EN_BNE(0), .EN_LOGIC_IMM(1), .ALUCTL_W(3)) dut_nobne (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .iord(iord2), .mem_write(mem_write2), .ir_write(ir_write2), .reg_dst(reg_dst2),
      .mem_to_reg(mem_to_reg2), .reg_write(reg_write2), .alu_src_a(alu_src_a2),
      .alu_src_b(alu_src_b2), .zext_imm(zext_imm2), .alu_control(alu_control2),
      .pc_src(pc_src2), .pc_en(pc_en2), .illegal_op(illegal_op2), .state_o(state_o2)
   );

   // Strobe cycle counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (reg_write === 1'b1) rw_cnt++;
      if (mem_write === 1'b1) mw_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
      #1;
      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         check("rst_state", state_o, 0);
         check("rst_strobes", {mem_write, reg_write, pc_en, ir_write, illegal_op}, 0);
         step();
      end
      rst_n = 1'b1; #1;
      check("fetch_pc_en", pc_en, 1);
      check("fetch_ir_write", ir_write, 1);
      check("fetch_srcb", alu_src_b, 2'b01);

      // lw: 0,1,2,3,4,0
      rw_base = rw_cnt;
      step(); check("lw_s1", state_o, 1);
      check("dec_srcb", alu_src_b, 2'b11);
      step(); check("lw_s2", state_o, 2);
      check("memadr_srcb", alu_src_b, 2'b10);
      step(); check("lw_s3", state_o, 3);
      check("memrd_iord", iord, 1);
      step(); check("lw_s4", state_o, 4);
      check("memwb_ctl", {reg_write, mem_to_reg, reg_dst}, 3'b110);
      step(); check("lw_done", state_o, 0);
      check("lw_rw_cycles", rw_cnt - rw_base, 1);

      // FETCH wait state.
      mem_ready = 1'b0; op = 6'b101011; #1;
      check("fetch_wait_pc_en", pc_en, 0);
      step(); check("fetch_wait_state", state_o, 0);

      // sw with two wait cycles in MEMWR.
      mem_ready = 1'b1; rw_base = rw_cnt; mw_base = mw_cnt;
      step(); step(); step();
      check("sw_memwr", state_o, 5);
      mem_ready = 1'b0; #1;
      step(); check("sw_hold1", state_o, 5);
      step(); check("sw_hold2", state_o, 5);
      mem_ready = 1'b1; #1;
      check("sw_iord", iord, 1);
      step(); check("sw_done", state_o, 0);
      check("sw_mw_cycles", mw_cnt - mw_base, 3);
      check("sw_no_rw", rw_cnt - rw_base, 0);

      // R-type slt.
      op = 6'b000000; funct = 6'b101010;
      step(); step();
      check("slt_exec", state_o, 6);
      check("slt_alu", alu_control, 3'b111);
      check("slt_srca", alu_src_a, 1);
      step(); check("slt_wb", {reg_write, reg_dst, mem_to_reg}, 3'b110);
      step(); check("slt_done", state_o, 0);

      // Illegal R-type funct.
      funct = 6'b000000; rw_base = rw_cnt;
      step(); check("ill_pulse", illegal_op, 1);
      step(); check("ill_state", state_o, 0);
      check("ill_pulse_gone", illegal_op, 0);
      check("ill_no_rw", rw_cnt - rw_base, 0);

      // beq taken and not taken.
      op = 6'b000100; funct = 6'b100000; zero = 1'b1;
      step(); step();
      check("beq_state", state_o, 8);
      check("beq_taken", {pc_en, pc_src}, 3'b101);
      check("beq_alu", alu_control, 3'b110);
      zero = 1'b0; #1;
      check("beq_not_taken", pc_en, 0);
      step(); check("beq_done", state_o, 0);

      // bne with zero=1: not taken; illegal when bne disabled.
      op = 6'b000101; zero = 1'b1;
      step();
      check("bne_dec_legal", illegal_op, 0);
      check("nobne_illegal", illegal_op2, 1);
      step(); check("bne_state", state_o, 8);
      check("bne_pc_en", pc_en, 0);
      check("nobne_fetch", state_o2, 0);
      step(); check("bne_done", state_o, 0);

      // ori: zero-extended, or.
      op = 6'b001101; zero = 1'b0;
      step(); step();
      check("ori_immex", state_o, 9);
      check("ori_ex_ctl", {zext_imm, alu_control}, 4'b1001);
      step(); check("ori_immwb", state_o, 10);
      check("ori_wb_ctl", {zext_imm, alu_control, reg_write}, 5'b10011);
      step(); check("ori_done", state_o, 0);

      // Jump.
      op = 6'b000010;
      step(); step();
      check("j_ctl", {state_o, pc_en, pc_src}, {4'd11, 1'b1, 2'b10});
      step(); check("j_done", state_o, 0);

      // Reset pulsed during IMMEX aborts the write.
      op = 6'b001101; rw_base = rw_cnt;
      step(); step();
      check("abort_immex", state_o, 9);
      rst_n = 1'b0; #1;
      check("abort_state", state_o, 0);
      check("abort_rw", reg_write, 0);
      step();
      rst_n = 1'b1; mem_ready = 1'b0; #1;
      step();
      check("abort_no_rw", rw_cnt - rw_base, 0);
      check("abort_fetch", state_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
